// File: rtl/uart8_pkg.sv
// Shared types and constants for the 8-bit UART transmit path.
package uart8_pkg;

  localparam int UART8_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } txState_t;

  // Bits needed to index n values; never less than 1 so vectors stay legal.
  function automatic int cntWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart8_tx_arbiter_rr_arbiter.sv
// Rotate-priority picker: first set request at or above ptr, wrapping around.
module rr_arbiter
  import uart8_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                  reqVec,
  input  logic [cntWidth(NUM_REQ)-1:0]        ptr,
  output logic [NUM_REQ-1:0]                  grantOh,
  output logic [cntWidth(NUM_REQ)-1:0]        grantIdx,
  output logic                                anyValid
);

  localparam int IW = cntWidth(NUM_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    grantOh  = '0;
    grantIdx = '0;
    anyValid = 1'b0;
    cand     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IW'((int'(ptr) + off) % NUM_REQ);
      if (!anyValid && reqVec[cand]) begin
        anyValid       = 1'b1;
        grantIdx       = cand;
        grantOh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart8_tx_arbiter.sv
// Round-robin sharing of the UART transmitter between NUM_REQ byte producers,
// with a start watchdog for a transmitter that never reports busy.
//
//   state | meaning
//   IDLE  | waiting for en, transmitter idle and a pending request
//   START | txStart held, waiting for txBusy (watchdog running)
//   SEND  | frame in flight, waiting for txDone or txBusy low
module uart8_tx_arbiter
  import uart8_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*8-1:0]          reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  output logic [$clog2(NUM_REQ)-1:0]    grantId,
  output logic                          txEn,
  output logic                          txStart,
  output logic [7:0]                    txIn,
  input  logic                          txBusy,
  input  logic                          txDone,
  output logic                          errTimeout
);

  localparam int IW = cntWidth(NUM_REQ);
  localparam int CW = cntWidth(START_TIMEOUT + 1);

  txState_t                state, stateNext;
  logic [IW-1:0]           ptr, ptrNext;
  logic [IW-1:0]           grantIdNext;
  logic [NUM_REQ-1:0]      reqReadyNext;
  logic [UART8_DATA_W-1:0] txInNext, selByte;
  logic                    errTimeoutNext;
  logic [CW-1:0]           wdCnt, wdCntNext;

  logic [NUM_REQ-1:0]      grantOh;
  logic [IW-1:0]           winIdx;
  logic                    anyValid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .reqVec   (reqValid),
    .ptr      (ptr),
    .grantOh  (grantOh),
    .grantIdx (winIdx),
    .anyValid (anyValid)
  );

  always_comb begin
    selByte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantOh[i]) selByte = selByte | reqData[8*i +: 8];
    end
  end

  always_comb begin
    stateNext      = state;
    ptrNext        = ptr;
    grantIdNext    = grantId;
    txInNext       = txIn;
    reqReadyNext   = '0;
    errTimeoutNext = 1'b0;
    wdCntNext      = wdCnt;
    case (state)
      IDLE: begin
        if (en && !txBusy && anyValid) begin
          reqReadyNext = grantOh;
          grantIdNext  = winIdx;
          txInNext     = selByte;
          ptrNext      = (winIdx == IW'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
          wdCntNext    = '0;
          stateNext    = START;
        end
      end
      START: begin
        if (txBusy) begin
          wdCntNext = '0;
          stateNext = SEND;
        end else if (wdCnt == CW'(START_TIMEOUT - 1)) begin
          // Byte is abandoned; ptr already moved past this requester.
          wdCntNext      = '0;
          errTimeoutNext = 1'b1;
          stateNext      = IDLE;
        end else if (wdCnt != {CW{1'b1}}) begin
          wdCntNext = wdCnt + 1'b1;
        end
      end
      SEND: begin
        if (txDone || !txBusy) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      ptr        <= '0;
      reqReady   <= '0;
      grantId    <= '0;
      txEn       <= 1'b0;
      txStart    <= 1'b0;
      txIn       <= '0;
      errTimeout <= 1'b0;
      wdCnt      <= '0;
    end else begin
      state      <= stateNext;
      ptr        <= ptrNext;
      reqReady   <= reqReadyNext;
      grantId    <= grantIdNext;
      txEn       <= en || (stateNext != IDLE);
      txStart    <= (stateNext == START);
      txIn       <= txInNext;
      errTimeout <= errTimeoutNext;
      wdCnt      <= wdCntNext;
    end
  end

endmodule

// File: tb/tb_uart8_tx_arbiter.sv
// Directed bench for uart8_tx_arbiter; expected grants are queued when
// requests are driven and matched against each reqReady pulse.
module tb_uart8_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic [1:0]  grantId;
  logic        txEn;
  logic        txStart;
  logic [7:0]  txIn;
  logic        txBusy;
  logic        txDone;
  logic        errTimeout;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
  } expGrant_t;

  expGrant_t sb[$];

  always #5 clk = ~clk;

  uart8_tx_arbiter #(.NUM_REQ(NREQ), .START_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .en         (en),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqReady   (reqReady),
    .grantId    (grantId),
    .txEn       (txEn),
    .txStart    (txStart),
    .txIn       (txIn),
    .txBusy     (txBusy),
    .txDone     (txDone),
    .errTimeout (errTimeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int id, input logic [7:0] d);
    expGrant_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic waitStart(input string tag);
    for (int i = 0; i < 30 && txStart !== 1'b1; i++) tick();
    check(tag, 32'(txStart), 32'd1);
  endtask

  task automatic finishFrame();
    txBusy = 1'b1;
    tick();
    tick();
    txBusy = 1'b0;
    tick();
  endtask

  // Every reqReady pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstN === 1'b1 && reqReady !== 4'b0000) begin
      check("readyOneHot", 32'($countones(reqReady)), 32'd1);
      check("readyNotWithErr", 32'(errTimeout), 32'd0);
      check("sbHasEntry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        expGrant_t e;
        e = sb.pop_front();
        check("grantReady", 32'(reqReady), 32'(4'b0001 << e.id));
        check("grantId", 32'(grantId), 32'(e.id));
        check("grantTxIn", 32'(txIn), 32'(e.data));
        check("grantTxStart", 32'(txStart), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL globalTimeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int hi;
    rstN     = 1'b0;
    en       = 1'b0;
    txBusy   = 1'b0;
    txDone   = 1'b0;
    reqValid = 4'b0000;
    reqData  = 32'h0;
    repeat (3) tick();

    check("rstReqReady", 32'(reqReady), 32'd0);
    check("rstGrantId", 32'(grantId), 32'd0);
    check("rstTxEn", 32'(txEn), 32'd0);
    check("rstTxStart", 32'(txStart), 32'd0);
    check("rstTxIn", 32'(txIn), 32'd0);
    check("rstErr", 32'(errTimeout), 32'd0);
    rstN = 1'b1;
    tick();
    check("idleEnLowTxEn", 32'(txEn), 32'd0);

    // single request
    en            = 1'b1;
    reqData[7:0]  = 8'hA5;
    reqValid      = 4'b0001;
    pushExp(0, 8'hA5);
    tick();
    check("singleStart", 32'(txStart), 32'd1);
    check("singleTxIn", 32'(txIn), 32'hA5);
    check("singleTxEn", 32'(txEn), 32'd1);
    reqValid = 4'b0000;
    tick();
    check("singleReadyPulse", 32'(reqReady), 32'd0);
    check("singleStartHeld", 32'(txStart), 32'd1);
    txBusy = 1'b1;
    tick();
    check("singleStartDrop", 32'(txStart), 32'd0);
    tick();
    check("sendHoldTxIn", 32'(txIn), 32'hA5);
    txBusy = 1'b0;
    tick();
    tick();
    check("singleIdle", 32'(txStart), 32'd0);

    // full contention from ptr=0
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    reqData  = 32'h13121110;
    reqValid = 4'b1111;
    pushExp(0, 8'h10);
    pushExp(1, 8'h11);
    pushExp(2, 8'h12);
    pushExp(3, 8'h13);
    pushExp(0, 8'h10);
    for (int k = 0; k < 5; k++) begin
      waitStart("contStart");
      check("contGrantSeq", 32'(grantId), 32'(k % 4));
      if (k == 4) reqValid = 4'b0000;
      finishFrame();
    end
    check("contDrained", 32'(sb.size()), 32'd0);

    // watchdog: transmitter never goes busy; ptr is 1
    reqData[15:8] = 8'h55;
    reqValid      = 4'b0010;
    pushExp(1, 8'h55);
    tick();
    check("wdStart", 32'(txStart), 32'd1);
    reqValid = 4'b0000;
    hi = 0;
    while (txStart === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    check("wdStartCycles", 32'(hi), 32'd16);
    check("wdErrPulse", 32'(errTimeout), 32'd1);
    tick();
    check("wdErrOnce", 32'(errTimeout), 32'd0);
    reqData  = 32'h13121110;
    reqValid = 4'b1111;
    pushExp(2, 8'h12);
    tick();
    check("wdNextGrant", 32'(grantId), 32'd2);
    reqValid = 4'b0000;
    finishFrame();

    // reset in the middle of SEND; ptr is 3
    reqData[7:0] = 8'h3C;
    reqValid     = 4'b0001;
    pushExp(0, 8'h3C);
    tick();
    check("rstMidStart", 32'(txStart), 32'd1);
    reqValid = 4'b0000;
    txBusy   = 1'b1;
    tick();
    check("rstMidSend", 32'(txStart), 32'd0);
    reqData[23:16] = 8'h77;
    reqValid       = 4'b0100;
    #2 rstN = 1'b0;
    #1;
    check("asyncTxStart", 32'(txStart), 32'd0);
    check("asyncTxEn", 32'(txEn), 32'd0);
    check("asyncTxIn", 32'(txIn), 32'd0);
    check("asyncGrantId", 32'(grantId), 32'd0);
    check("asyncReqReady", 32'(reqReady), 32'd0);
    check("asyncErr", 32'(errTimeout), 32'd0);
    tick();
    rstN = 1'b1;
    repeat (3) begin
      tick();
      check("busyBlocksGrant", 32'(txStart), 32'd0);
    end
    pushExp(2, 8'h77);
    txBusy = 1'b0;
    tick();
    check("postResetGrant", 32'(txStart), 32'd1);
    reqValid = 4'b0000;
    finishFrame();

    // en dropped mid-frame; ptr is 3
    reqData[31:24] = 8'h99;
    reqValid       = 4'b1000;
    pushExp(3, 8'h99);
    tick();
    check("enStart", 32'(txStart), 32'd1);
    reqValid = 4'b0000;
    txBusy   = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check("enDropSendTxEn", 32'(txEn), 32'd1);
    txBusy = 1'b0;
    tick();
    check("enDropIdleTxEn", 32'(txEn), 32'd0);
    reqData[7:0] = 8'h42;
    reqValid     = 4'b0001;
    repeat (5) begin
      tick();
      check("enLowNoGrant", 32'(txStart), 32'd0);
    end
    en = 1'b1;
    pushExp(0, 8'h42);
    tick();
    check("enHighGrant", 32'(txStart), 32'd1);
    reqValid = 4'b0000;

    // txDone together with txBusy ends SEND
    txBusy = 1'b1;
    tick();
    tick();
    txDone        = 1'b1;
    reqData[15:8] = 8'h66;
    reqValid      = 4'b0010;
    pushExp(1, 8'h66);
    tick();
    txDone = 1'b0;
    txBusy = 1'b0;
    check("doneExitNoStart", 32'(txStart), 32'd0);
    tick();
    check("doneTurnaround", 32'(txStart), 32'd1);
    reqValid = 4'b0000;
    finishFrame();
    check("finalDrained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/uart8_tx_arbiter.md
# uart8_tx_arbiter

Shares the single transmit channel of the 8-bit UART between `NUM_REQ` independent byte producers. Round-robin arbitration with per-requester valid/ready handshake. Sequences the transmitter's `txEn`/`txStart`/`txIn` inputs from its `txBusy`/`txDone` status. A start watchdog recovers from a transmitter that never acknowledges. Sits between the on-chip byte sources and the UART top level, on the board clock.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `START_TIMEOUT`, 65535: board-clock cycles to wait for `txBusy` after raising `txStart`, 1..2^20.

Ports:
- `clk` input, 1: board clock.
- `rstN` input, 1: asynchronous, active-low reset.
- `en` input, 1: gates new grants; an in-flight frame always completes.
- `reqValid` input, `NUM_REQ`: byte pending, one bit per requester.
- `reqData` input, `NUM_REQ*8`: byte i on bits [8i+7:8i].
- `reqReady` output, `NUM_REQ`: one-cycle pulse; byte i captured this cycle.
- `grantId` output, `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `txEn` output, 1: transmitter enable.
- `txStart` output, 1: transmitter start request.
- `txIn` output, 8: byte to transmit.
- `txBusy` input, 1: transmitter busy status.
- `txDone` input, 1: transmitter frame-done status.
- `errTimeout` output, 1: one-cycle pulse; frame dropped on watchdog expiry.

## Operation

- FSM states: IDLE, START, SEND.
- **IDLE:** grant is allowed when `en`=1, `txBusy`=0 and any `reqValid` is set.
  - Winner: the first set bit scanning upward from `ptr` with wrap-around.
  - Grant cycle: `reqReady[winner]`=1, `txIn`<=byte, `grantId`<=winner, `ptr`<=winner+1 mod `NUM_REQ`. Go to START.
- **START:** hold `txStart`=1 and `txIn` stable. Watchdog counter increments every cycle.
  - `txBusy`=1: drop `txStart`, clear the counter, go to SEND.
  - Counter reaches `START_TIMEOUT`-1 with `txBusy` still 0: drop `txStart`, pulse `errTimeout`, go to IDLE. The byte is dropped and `ptr` has already advanced.
- **SEND:** wait for `txBusy`=0 or `txDone`=1, then go to IDLE. `txIn` is held until exit.
- `txEn`=1 whenever `en`=1 or the state is not IDLE. Deasserting `en` mid-frame does not abort the frame.
- At most one `reqReady` bit is high in any cycle. `reqReady` never asserts outside IDLE.
- Requesters keep `reqValid`/`reqData` stable until they see `reqReady`. Dropping `reqValid` without `reqReady` is legal and simply withdraws the request.
- Simultaneous requests are served strictly round-robin. With all requesters valid, each gets one frame per `NUM_REQ` grants.

## Timing

- Reset values: state IDLE, `ptr`=0, `reqReady`=0, `grantId`=0, `txEn`=0, `txStart`=0, `txIn`=8'h00, `errTimeout`=0, watchdog counter 0.
- Reset mid-frame: all outputs return to reset values asynchronously.
  - The transmitter may still be busy after reset. IDLE's `txBusy`=0 condition blocks any grant until it finishes.
- All outputs are registered. No combinational path from `reqValid` or `txBusy` to any output.
- Latency: `reqValid` rising in IDLE → `reqReady` pulse and `txStart`=1 on the next `clk` edge (1 cycle).
- `txStart` stays high from entering START until the cycle after `txBusy` is first sampled high.
  - This covers the transmitter running on a slower baud-derived clock.
- SEND exits on the first cycle `txBusy`=0 or `txDone`=1. The next grant is possible on the following cycle.
  - Minimum turnaround from frame end to the next `txStart` is 2 cycles.
- `txDone` and `txBusy` both high in the same cycle: `txDone` wins and SEND exits.
- Watchdog counter width is `$clog2(START_TIMEOUT+1)`. It saturates and cannot wrap.
- `errTimeout` and `reqReady` never assert in the same cycle.

## Structure

- Shared package `uart8_pkg`:
  - state enum (IDLE/START/SEND),
  - `UART8_DATA_W`=8,
  - a `clog2`-based width helper.
- Sub-module `rr_arbiter`:
  - `NUM_REQ`-wide rotate-priority picker, combinational;
  - inputs: request vector and `ptr`;
  - outputs: one-hot grant, encoded index, any-valid flag.
- The FSM, watchdog, and capture registers live in `uart8_tx_arbiter`.

## Test plan

- Single request: `reqValid`=4'b0001, byte 8'hA5 → `reqReady[0]` pulse 1 cycle later, `txStart`=1, `txIn`=8'hA5. Transmitter model raises `txBusy` → `txStart` drops. `txBusy` falls → back in IDLE.
- Full contention: all 4 requesters valid with bytes 8'h10..8'h13, `ptr`=0 → grant order 0,1,2,3,0; `grantId` sequence matches. No two `reqReady` bits ever high together.
- Watchdog: `START_TIMEOUT`=16, transmitter model never raises `txBusy` → `txStart` high for exactly 16 cycles, then `errTimeout` pulses once. Next grant goes to `ptr`+1.
- Reset mid-SEND with `txBusy` still 1 → all outputs reset asynchronously. A pending `reqValid` is not granted until `txBusy`=0.
- `en` dropped during SEND → frame completes and `txEn` stays 1 until IDLE, then `txEn`=0. No new grant while `en`=0 despite `reqValid`=1.
- `txDone` and `txBusy` both high in one cycle during SEND → exit to IDLE. Next `txStart` occurs 2 cycles after that `txDone` pulse.
